// File: rtl/hammer_pkg.sv
// Shared types and constants for the hammer sprite motion controller:
// swing phases, HID keycodes and default screen geometry.
package hammer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WINDUP  = 2'd1,
        STRIKE  = 2'd2,
        RECOVER = 2'd3
    } swing_phase_t;

    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    localparam int X_CENTER_DEF = 320;
    localparam int Y_CENTER_DEF = 240;
    localparam int X_MIN_DEF    = 0;
    localparam int X_MAX_DEF    = 639;
    localparam int Y_MIN_DEF    = 0;
    localparam int Y_MAX_DEF    = 479;

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the vertical-sync level into the Clk domain and emits a one-cycle
// tick per rising edge (2-flop synchroniser plus one delay flop).
module frame_tick_sync (
    input  logic clk,
    input  logic reset,
    input  logic frame_clk,
    output logic tick
);

    logic sync_1, sync_2, delay;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            delay  <= 1'b0;
        end else begin
            sync_1 <= frame_clk;
            sync_2 <= sync_1;
            delay  <= sync_2;
        end
    end

    assign tick = sync_2 & ~delay;

endmodule

// File: rtl/hammer_motion.sv
// Per-frame hammer sprite motion plus four-phase swing FSM. Define
// HAMMER_BOUNCE_EN to reflect off screen edges; otherwise the sprite clamps.
module hammer_motion
    import hammer_pkg::*;
#(
    parameter int X_CENTER     = X_CENTER_DEF,
    parameter int Y_CENTER     = Y_CENTER_DEF,
    parameter int X_MIN        = X_MIN_DEF,
    parameter int X_MAX        = X_MAX_DEF,
    parameter int Y_MIN        = Y_MIN_DEF,
    parameter int Y_MAX        = Y_MAX_DEF,
    parameter int STEP         = 1,
    parameter int SIZE         = 4,
    parameter int SWING_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] BallS,
    output logic [1:0] swing_phase,
    output logic       strike
);

    localparam int              CNT_W    = $clog2(SWING_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SWING_FRAMES - 1);
    localparam logic [9:0]      STEP_P   = 10'(STEP);
    localparam logic [9:0]      STEP_N   = 10'(-STEP);

`ifdef HAMMER_BOUNCE_EN
    localparam logic [10:0] SIZE_W = 11'(SIZE);
    localparam logic [10:0] X_MAX_W = 11'(X_MAX);
    localparam logic [10:0] Y_MAX_W = 11'(Y_MAX);
    localparam logic [10:0] X_LO_W  = 11'(X_MIN + SIZE);
    localparam logic [10:0] Y_LO_W  = 11'(Y_MIN + SIZE);
`else
    localparam logic signed [11:0] X_LO = 12'(X_MIN + SIZE);
    localparam logic signed [11:0] X_HI = 12'(X_MAX - SIZE);
    localparam logic signed [11:0] Y_LO = 12'(Y_MIN + SIZE);
    localparam logic signed [11:0] Y_HI = 12'(Y_MAX - SIZE);
    logic signed [11:0] x_sum, y_sum;
`endif

    swing_phase_t     phase;
    logic [CNT_W-1:0] frame_cnt;
    logic [9:0]       mx, my, mx_key, my_key, mx_next, my_next, x_next, y_next;
    logic             tick, frozen;

    frame_tick_sync u_tick (
        .clk       (Clk),
        .reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    assign frozen      = (phase == WINDUP) || (phase == STRIKE);
    assign BallS       = 10'(SIZE);
    assign swing_phase = phase;

    always_comb begin
        mx_key = mx;
        my_key = my;
        case (keycode)
            KEY_A: begin mx_key = STEP_N; my_key = '0;     end
            KEY_D: begin mx_key = STEP_P; my_key = '0;     end
            KEY_W: begin mx_key = '0;     my_key = STEP_N; end
            KEY_S: begin mx_key = '0;     my_key = STEP_P; end
            default: ;
        endcase
`ifdef HAMMER_BOUNCE_EN
        mx_next = mx_key;
        my_next = my_key;
        if ({1'b0, BallX} + SIZE_W >= X_MAX_W)  mx_next = STEP_N;
        else if ({1'b0, BallX} <= X_LO_W)       mx_next = STEP_P;
        if ({1'b0, BallY} + SIZE_W >= Y_MAX_W)  my_next = STEP_N;
        else if ({1'b0, BallY} <= Y_LO_W)       my_next = STEP_P;
        x_next = BallX + mx_next;
        y_next = BallY + my_next;
`else
        // Sum in 12-bit signed so a step below zero is seen as below the limit.
        x_sum   = $signed({2'b00, BallX}) + $signed({{2{mx_key[9]}}, mx_key});
        y_sum   = $signed({2'b00, BallY}) + $signed({{2{my_key[9]}}, my_key});
        x_next  = x_sum[9:0];
        y_next  = y_sum[9:0];
        mx_next = mx_key;
        my_next = my_key;
        if (x_sum > X_HI)      begin x_next = X_HI[9:0]; mx_next = '0; end
        else if (x_sum < X_LO) begin x_next = X_LO[9:0]; mx_next = '0; end
        if (y_sum > Y_HI)      begin y_next = Y_HI[9:0]; my_next = '0; end
        else if (y_sum < Y_LO) begin y_next = Y_LO[9:0]; my_next = '0; end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            BallX     <= 10'(X_CENTER);
            BallY     <= 10'(Y_CENTER);
            mx        <= '0;
            my        <= '0;
            phase     <= IDLE;
            frame_cnt <= '0;
            strike    <= 1'b0;
        end else begin
            strike <= 1'b0;
            if (tick) begin
                if (!frozen) begin
                    BallX <= x_next;
                    BallY <= y_next;
                    mx    <= mx_next;
                    my    <= my_next;
                end
                if (phase == IDLE) begin
                    if (keycode == KEY_SPACE) begin
                        phase     <= WINDUP;
                        frame_cnt <= '0;
                    end
                end else if (frame_cnt == CNT_LAST) begin
                    // Phases are sequential; RECOVER + 1 wraps back to IDLE.
                    phase     <= swing_phase_t'(phase + 2'd1);
                    frame_cnt <= '0;
                    strike    <= (phase == WINDUP);
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hammer_motion.sv
// Self-checking bench for hammer_motion: directed scenarios with literal
// expectations plus random keycode frames, all tracked by a per-frame model.
`timescale 1ns/1ps
module tb_hammer_motion;

    localparam int XC = 320, YC = 240;
    localparam int XMIN = 0, XMAX = 639, YMIN = 0, YMAX = 479;
    localparam int STEP = 1, SIZE = 4, SF = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic [9:0] ball_x, ball_y, ball_s;
    logic [1:0] swing_phase;
    logic       strike;

    int total = 0;
    int bad = 0;

    hammer_motion #(.SWING_FRAMES(SF)) dut (
        .Clk         (clk),
        .Reset       (reset),
        .frame_clk   (frame_clk),
        .keycode     (keycode),
        .BallX       (ball_x),
        .BallY       (ball_y),
        .BallS       (ball_s),
        .swing_phase (swing_phase),
        .strike      (strike)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        total++;
        if (act !== 32'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: position, motion and swing phase per frame.
    int m_x, m_y, m_mx, m_my, m_ph, m_ticks_in_phase;
    bit m_strike;
    int pend = 0;
    bit fc_last = 1'b0;
    bit model_valid = 1'b0;
    int strike_seen = 0;

    function automatic int wrap10(input int v);
        return ((v % 1024) + 1024) % 1024;
    endfunction

    task automatic clamp_axis(input int p, input int m, input int lo, input int hi,
                              output int p_o, output int m_o);
        int n;
        n = p + m;
        p_o = n;
        m_o = m;
        if (n > hi) begin p_o = hi; m_o = 0; end
        else if (n < lo) begin p_o = lo; m_o = 0; end
    endtask

    task automatic model_step(input logic [7:0] k);
        bit frozen;
        int px, pm;
        frozen = (m_ph == 1) || (m_ph == 2);
        if (!frozen) begin
            case (k)
                8'h04: begin m_mx = -STEP; m_my = 0; end
                8'h07: begin m_mx = STEP;  m_my = 0; end
                8'h1A: begin m_my = -STEP; m_mx = 0; end
                8'h16: begin m_my = STEP;  m_mx = 0; end
                default: ;
            endcase
`ifdef HAMMER_BOUNCE_EN
            if (m_x + SIZE >= XMAX) m_mx = -STEP;
            else if (m_x <= XMIN + SIZE) m_mx = STEP;
            if (m_y + SIZE >= YMAX) m_my = -STEP;
            else if (m_y <= YMIN + SIZE) m_my = STEP;
            m_x = wrap10(m_x + m_mx);
            m_y = wrap10(m_y + m_my);
`else
            clamp_axis(m_x, m_mx, XMIN + SIZE, XMAX - SIZE, px, pm);
            m_x = px; m_mx = pm;
            clamp_axis(m_y, m_my, YMIN + SIZE, YMAX - SIZE, px, pm);
            m_y = px; m_my = pm;
`endif
        end
        if (m_ph == 0) begin
            if (k == 8'h2C) begin m_ph = 1; m_ticks_in_phase = 0; end
        end else begin
            m_ticks_in_phase++;
            if (m_ticks_in_phase == SF) begin
                m_ticks_in_phase = 0;
                if (m_ph == 1) m_strike = 1'b1;
                m_ph = (m_ph + 1) % 4;
            end
        end
    endtask

    // A frame_clk rise first seen at one edge takes effect two edges later.
    always @(posedge clk) begin
        m_strike = 1'b0;
        if (reset) begin
            m_x = XC; m_y = YC; m_mx = 0; m_my = 0;
            m_ph = 0; m_ticks_in_phase = 0;
            pend = 0; fc_last = 1'b0; model_valid = 1'b1;
        end else begin
            if (pend == 2) begin model_step(keycode); pend = 0; end
            else if (pend == 1) pend = 2;
            if (frame_clk && !fc_last) pend = 1;
            fc_last = frame_clk;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("cyc_ball_x", ball_x, m_x);
            chk("cyc_ball_y", ball_y, m_y);
            chk("cyc_ball_s", ball_s, SIZE);
            chk("cyc_phase", swing_phase, m_ph);
            chk("cyc_strike", strike, m_strike);
            if (strike === 1'b1) strike_seen++;
        end
    end

    task automatic frame(input logic [7:0] k);
        @(negedge clk);
        keycode = k;
        frame_clk = 1'b1;
        repeat (2) @(negedge clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        frame_clk = 1'b0;
        keycode = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    int exp_ph[6] = '{1, 2, 2, 3, 3, 0};
    int exp_x[6]  = '{328, 328, 328, 328, 329, 330};
    int s0;
    logic [7:0] rk;

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_x", ball_x, 320);
        chk("rst_y", ball_y, 240);
        chk("rst_phase", swing_phase, 0);
        chk("rst_strike", strike, 0);
        chk("rst_size", ball_s, 4);

        s0 = strike_seen;
        repeat (3) frame(8'h00);
        chk("idle_x", ball_x, 320);
        chk("idle_y", ball_y, 240);
        chk("idle_no_strike", strike_seen - s0, 0);

        repeat (5) frame(8'h07);
        chk("right5_x", ball_x, 325);
        chk("right5_y", ball_y, 240);
        repeat (2) frame(8'h00);
        chk("persist_x", ball_x, 327);

        s0 = strike_seen;
        frame(8'h2C);
        chk("swing_start_phase", swing_phase, 1);
        chk("swing_start_x", ball_x, 328);
        for (int i = 0; i < 6; i++) begin
            frame(8'h07);
            chk("swing_phase_seq", swing_phase, exp_ph[i]);
            chk("swing_x_seq", ball_x, exp_x[i]);
        end
        chk("strike_pulses", strike_seen - s0, 1);

        repeat (304) frame(8'h07);
        chk("edge_approach_x", ball_x, 634);
        frame(8'h07);
        chk("edge_reach_x", ball_x, 635);
`ifdef HAMMER_BOUNCE_EN
        frame(8'h07);
        chk("edge_bounce_x", ball_x, 634);
        frame(8'h00);
        chk("edge_after_x", ball_x, 633);
        frame(8'h04);
        chk("edge_left_x", ball_x, 632);
`else
        frame(8'h07);
        chk("edge_clamp_x", ball_x, 635);
        frame(8'h00);
        chk("edge_hold_x", ball_x, 635);
        frame(8'h04);
        chk("edge_left_x", ball_x, 634);
`endif

        frame(8'h2C);
        frame(8'h00);
        frame(8'h00);
        chk("pre_reset_phase", swing_phase, 2);
        @(negedge clk);
        reset = 1'b1;
        frame_clk = 1'b1;
        @(negedge clk);
        chk("midswing_rst_phase", swing_phase, 0);
        chk("midswing_rst_x", ball_x, 320);
        chk("midswing_rst_y", ball_y, 240);
        repeat (2) @(negedge clk);
        frame_clk = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("no_residual_x", ball_x, 320);
        chk("no_residual_phase", swing_phase, 0);

        repeat (240) frame(8'h1A);
        chk("top_edge_y", ball_y, 4);
        chk("top_edge_x", ball_x, 320);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0: rk = 8'h00;
                1: rk = 8'h04;
                2: rk = 8'h07;
                3: rk = 8'h1A;
                4: rk = 8'h16;
                5: rk = 8'h2C;
                default: rk = 8'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 49) == 0) do_reset();
            frame(rk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hammer_motion.md
Name: hammer_motion

Overview:
- Per-frame motion controller for the player hammer sprite; sits directly upstream of the colour mapper.
- Supplies sprite centre X/Y and size, plus swing status, to the colour mapper.
- Samples the vertical-sync frame strobe and the keyboard keycode; updates position once per frame.
- Runs a four-phase hammer-swing FSM that freezes movement while a strike is in progress.

Parameters:
- X_CENTER, 320, reset X position (pixels)
- Y_CENTER, 240, reset Y position
- X_MIN, 0, left limit; X_MAX, 639, right limit
- Y_MIN, 0, top limit; Y_MAX, 479, bottom limit
- STEP, 1, pixels moved per frame
- SIZE, 4, sprite half-size, driven on BallS
- SWING_FRAMES, 8, frames spent in each swing phase (≥1)

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset  in  1  synchronous, active-high
- frame_clk  in  1  vertical-sync strobe, asynchronous to pixel content, level signal
- keycode  in  8  current USB HID keycode, 0 = none
- BallX  out  10  sprite centre X
- BallY  out  10  sprite centre Y
- BallS  out  10  sprite half-size (constant SIZE)
- swing_phase  out  2  0 IDLE, 1 WINDUP, 2 STRIKE, 3 RECOVER
- strike  out  1  high for exactly one Clk on entry to STRIKE

Behaviour:
- Clocking and reset:
  - Single clock Clk; Reset is synchronous and active-high; every register resets on the Clk edge where Reset=1.
  - Reset values: BallX=X_CENTER, BallY=Y_CENTER, motion X/Y=0, swing_phase=IDLE, frame counter=0, strike=0, frame_clk delay reg=0.
  - Reset asserted mid-swing or mid-motion returns to these values immediately; no residual tick.
- Frame tick:
  - frame_clk is passed through a 2-flop synchroniser plus one delay flop.
  - tick = sync & ~delay, i.e. one Clk per rising edge of frame_clk.
  - All position and FSM updates occur on the Clk edge where tick=1; outputs are visible 3 Clk after the frame_clk rising edge.
  - Between ticks all outputs hold.
- Motion (signed 10-bit two's-complement step register per axis), evaluated on tick:
  - Keycode 0x04 (A): mx=-STEP, my=0.
  - 0x07 (D): mx=+STEP, my=0.
  - 0x1A (W): my=-STEP, mx=0.
  - 0x16 (S): my=+STEP, mx=0.
  - Other or zero: keep previous motion (persistent).
  - Edge check overrides the key: if BallX+SIZE ≥ X_MAX, then mx=-STEP; else if BallX ≤ X_MIN+SIZE, then mx=+STEP. Y is handled likewise.
  - Position update on the same tick: BallX = BallX + mx_next, BallY = BallY + my_next, modulo 2^10.
  - Comparisons are unsigned on the current position.
- Swing FSM:
  - IDLE→WINDUP on tick with keycode 0x2C (space).
  - WINDUP→STRIKE after SWING_FRAMES ticks.
  - STRIKE→RECOVER after SWING_FRAMES ticks.
  - RECOVER→IDLE after SWING_FRAMES ticks.
  - The frame counter clears on every state change.
  - Space pressed outside IDLE is ignored, with no queueing.
  - While in WINDUP or STRIKE, position and motion registers hold (key and edge logic suppressed). RECOVER and IDLE move normally.
  - strike pulses for one Clk on the WINDUP→STRIKE transition.
- Simultaneous events: a space plus direction key on the same tick starts the swing. Since the FSM is IDLE on that tick, the motion update still applies that tick; the freeze begins next tick.

Optional Feature:
- Macro: HAMMER_BOUNCE_EN.
- Defined: edge behaviour as above (reflect direction).
- Undefined: clamp instead of reflecting.
  - If the next position would pass X_MAX-SIZE or X_MIN+SIZE (same for Y), set the position to that limit and set the axis motion to 0.
  - A new key press in the opposite direction resumes motion.

Decomposition:
- Package hammer_pkg:
  - swing_phase_t enum (IDLE, WINDUP, STRIKE, RECOVER).
  - keycode constants KEY_A, KEY_D, KEY_W, KEY_S, KEY_SPACE.
  - Screen limit defaults.
- One sub-module, frame_tick_sync: 2-flop synchroniser plus rising-edge detector producing tick.

Test Plan:
- Reset then 3 frame_clk pulses, keycode=0 → BallX=320, BallY=240, swing_phase=0, strike never high.
- keycode=0x07 for 5 ticks → BallX=325, BallY=240; keycode→0 for 2 more ticks → BallX=327 (persistent motion).
- Start BallX=634 (via 0x07, SIZE=4), with HAMMER_BOUNCE_EN defined → BallX reaches 635, next tick 634, then decreasing.
- Same stimulus with the macro undefined → BallX clamps at 635, stays at 635, mx=0; 0x04 → 634.
- keycode=0x2C on one tick with SWING_FRAMES=2 → phases 1,1,2,2,3,3,0 over successive ticks; strike high exactly 1 Clk; BallX frozen during phases 1–2 despite 0x07.
- Reset asserted during STRIKE → next Clk swing_phase=0, BallX=320, BallY=240; a frame_clk edge coincident with Reset produces no update.
